uart_transmitter: RTL and testbench

Byte-oriented UART transmitter with an input FIFO, the transmit counterpart of the design's UART receiver. It sends status bytes from the FPGA back to the Arduino/GY521 sensor board over a GPIO_1 pin, e.g. current note index, wave select, or filter state. Framing is 8N1 at a configurable baud rate, LSB first. The optional even-parity bit is described under Configuration.

---
 rtl/uart_transmitter.sv | 216 +++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Byte-oriented UART transmitter with an input FIFO. Sends status bytes from
// the FPGA to the sensor board, 8N1 framing, LSB first, at CLK_FREQ/BAUD
// clocks per bit.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> 8E1 framing, an even-parity bit between data and stop.
//   undefined -> 8N1 framing, no parity state or logic.
//
// Parameters:
//   CLK_FREQ    input clock frequency in Hz
//   BAUD        line rate in bit/s (CLK_FREQ/BAUD must be >= 2)
//   FIFO_DEPTH  input FIFO depth in bytes (power of 2, >= 2)
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   tx_data     in   byte to send
//   tx_valid    in   tx_data valid this cycle
//   tx_ready    out  FIFO not full (registered)
//   tx          out  serial line, idles high (registered)
//   busy        out  frame on the line or FIFO non-empty
//   fifo_count  out  bytes queued, excluding the byte in flight (registered)
// ---------------------------------------------------------------------------
module uart_transmitter #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          CLOCK_50,
   input  logic                          reset_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = PTR_W + 1;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LOAD  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift;
`ifdef UART_TX_PARITY_EN
   logic              parity_bit;
`endif

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  next_count;

   logic push;
   logic pop;
   logic bit_end;

   // tx_ready is a register, so push never depends combinationally on itself.
   assign push    = tx_valid && tx_ready;
   assign bit_end = (baud_cnt == '0);

   // Pop from IDLE, or on the last stop-bit cycle so the next start bit
   // follows with no idle gap.
   assign pop = (fifo_count != '0) &&
                ((state == S_IDLE) || ((state == S_STOP) && bit_end));

   assign busy = (state != S_IDLE) || (fifo_count != '0);

   // NOTE: every variable written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      next_count = fifo_count;
      if (push && !pop) next_count = fifo_count + CNT_W'(1);
      if (pop && !push) next_count = fifo_count - CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= next_count;
         tx_ready   <= (next_count != FULL_COUNT);
      end
   end

   // NOTE: the storage array has no reset; the pointers and count define
   // which entries are valid, so stale contents are never observed.
   always_ff @(posedge CLOCK_50) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (pop) begin
            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
         end

         unique case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  state    <= S_START;
                  tx       <= 1'b0;
                  baud_cnt <= BAUD_LOAD;
                  bit_idx  <= '0;
               end
            end

            S_START: begin
               if (bit_end) begin
                  state    <= S_DATA;
                  tx       <= shift[0];
                  baud_cnt <= BAUD_LOAD;
                  bit_idx  <= '0;
               end else begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= S_PARITY;
                     tx    <= parity_bit;
`else
                     state <= S_STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     // Next line value is the bit about to shift into [0].
                     tx      <= shift[1];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  state    <= S_STOP;
                  tx       <= 1'b1;
                  baud_cnt <= BAUD_LOAD;
               end else begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end
            end
`endif

            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= BAUD_LOAD;
                  bit_idx  <= '0;
                  if (pop) begin
                     state <= S_START;
                     tx    <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BAUD_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter with CLK_FREQ=16, BAUD=1 (16 clocks
// per bit) and FIFO_DEPTH=4. A small line receiver samples tx at bit
// centres; expected frames are built from the pushed bytes.
// Define UART_TX_PARITY_EN for both bench and design to cover 8E1.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC    = NBITS * CPB;
   localparam int WAIT_BUDGET  = 400;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   uart_transmitter #(
      .CLK_FREQ   (16),
      .BAUD       (1),
      .FIFO_DEPTH (4)
   ) dut (
      .CLOCK_50   (clk),
      .reset_n    (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Expected line bits, index 0 = start bit, sent first.
   function automatic logic [NBITS-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, d, 1'b0};
`endif
   endfunction

   // Wait (bounded) for a falling edge on tx, then sample every bit centre.
   task automatic rx_frame(output logic [NBITS-1:0] bits, output int fall,
                           output bit ok);
      ok   = 1'b0;
      fall = -1;
      bits = '1;
      for (int i = 0; i < WAIT_BUDGET; i++) begin
         @(posedge clk); #1;
         if (tx === 1'b0) begin
            fall = cyc;
            ok   = 1'b1;
            break;
         end
      end
      if (!ok) return;
      repeat (CPB / 2) @(posedge clk);
      #1 bits[0] = tx;
      for (int b = 1; b < NBITS; b++) begin
         repeat (CPB) @(posedge clk);
         #1 bits[b] = tx;
      end
   endtask

   task automatic wait_not_busy(output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < WAIT_BUDGET; i++) begin
         @(posedge clk); #1;
         if (busy === 1'b0) begin
            at = cyc;
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Count start-bit falls over n cycles.
   task automatic watch_idle(input int n, output int falls);
      logic prev;
      falls = 0;
      prev  = tx;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (prev === 1'b1 && tx === 1'b0) falls++;
         prev = tx;
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      for (int c = 0; c < 4; c++) begin
         if (c < 3) @(negedge clk);
         else begin
            rst_n = 1'b1;
            @(posedge clk); #1;
         end
         checks++; if (tx !== 1'b1)
            begin errors++; $display("FAIL reset_tx c=%0d: got %b want 1", c, tx); end
         checks++; if (tx_ready !== 1'b1)
            begin errors++; $display("FAIL reset_tx_ready c=%0d: got %b want 1", c, tx_ready); end
         checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL reset_busy c=%0d: got %b want 0", c, busy); end
         checks++; if (fifo_count !== 3'd0)
            begin errors++; $display("FAIL reset_fifo_count c=%0d: got %0d want 0", c, fifo_count); end
      end
   endtask

   task automatic test_single_byte(input logic [7:0] d, input string name);
      logic [NBITS-1:0] bits;
      int e0, fall, drop;
      bit ok, ok2;
      e0 = 0;
      fork
         begin
            @(negedge clk);
            tx_data  = d;
            tx_valid = 1'b1;
            @(posedge clk); #1;
            tx_valid = 1'b0;
            e0 = cyc;
            checks++; if (fifo_count !== 3'd1)
               begin errors++; $display("FAIL %s_count_after_push: got %0d want 1", name, fifo_count); end
            checks++; if (busy !== 1'b1)
               begin errors++; $display("FAIL %s_busy_after_push: got %b want 1", name, busy); end
         end
         rx_frame(bits, fall, ok);
      join
      checks++; if (!ok)
         begin errors++; $display("FAIL %s_start_timeout: got no start bit want one", name); end
      checks++; if (fall - e0 !== 1)
         begin errors++; $display("FAIL %s_latency: got %0d want 1", name, fall - e0); end
      checks++; if (bits !== frame_of(d))
         begin errors++; $display("FAIL %s_frame: got %b want %b", name, bits, frame_of(d)); end
      wait_not_busy(drop, ok2);
      checks++; if (!ok2 || (drop - fall) !== FRAME_CYC)
         begin errors++; $display("FAIL %s_frame_len: got %0d want %0d", name, drop - fall, FRAME_CYC); end
   endtask

   task automatic test_back_to_back();
      logic [NBITS-1:0] bits0, bits1;
      int fall0, fall1, at;
      bit ok0, ok1, ok2;
      fork
         begin
            @(negedge clk);
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (fifo_count !== 3'd1)
               begin errors++; $display("FAIL b2b_count_first: got %0d want 1", fifo_count); end
            tx_data = 8'hFF;
            @(posedge clk); #1;
            tx_valid = 1'b0;
            checks++; if (fifo_count !== 3'd1)
               begin errors++; $display("FAIL b2b_count_second: got %0d want 1", fifo_count); end
         end
         begin
            rx_frame(bits0, fall0, ok0);
            rx_frame(bits1, fall1, ok1);
         end
      join
      checks++; if (!ok0 || !ok1)
         begin errors++; $display("FAIL b2b_start_timeout: got %b%b want 11", ok0, ok1); end
      checks++; if (bits0 !== frame_of(8'h00))
         begin errors++; $display("FAIL b2b_frame0: got %b want %b", bits0, frame_of(8'h00)); end
      checks++; if (bits1 !== frame_of(8'hFF))
         begin errors++; $display("FAIL b2b_frame1: got %b want %b", bits1, frame_of(8'hFF)); end
      checks++; if (fall1 - fall0 !== FRAME_CYC)
         begin errors++; $display("FAIL b2b_gap: got %0d want %0d", fall1 - fall0, FRAME_CYC); end
      checks++; if (fifo_count !== 3'd0)
         begin errors++; $display("FAIL b2b_count_final: got %0d want 0", fifo_count); end
      wait_not_busy(at, ok2);
      checks++; if (!ok2)
         begin errors++; $display("FAIL b2b_busy_timeout: got busy=%b want 0", busy); end
   endtask

   task automatic test_fifo_full();
      logic [7:0] vals [6];
      logic [NBITS-1:0] bits;
      int fall, falls;
      bit ok;
      logic exp_rdy;
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'h66;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               tx_data  = vals[i];
               tx_valid = 1'b1;
               exp_rdy  = (i < 5) ? 1'b1 : 1'b0;
               checks++; if (tx_ready !== exp_rdy)
                  begin errors++; $display("FAIL full_ready push%0d: got %b want %b", i, tx_ready, exp_rdy); end
               @(posedge clk); #1;
               tx_valid = 1'b0;
            end
            checks++; if (fifo_count !== 3'd4)
               begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
         end
         begin
            for (int f = 0; f < 5; f++) begin
               rx_frame(bits, fall, ok);
               checks++; if (!ok || bits !== frame_of(vals[f]))
                  begin errors++; $display("FAIL full_frame%0d: got %b want %b", f, bits, frame_of(vals[f])); end
            end
         end
      join
      watch_idle(3 * FRAME_CYC, falls);
      checks++; if (falls !== 0)
         begin errors++; $display("FAIL full_extra_frames: got %0d want 0", falls); end
      checks++; if (busy !== 1'b0)
         begin errors++; $display("FAIL full_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_frame();
      logic [NBITS-1:0] bits;
      int fall, falls;
      bit ok;
      @(negedge clk);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_data  = 8'h5A;          // queued behind 0x3C, must be discarded
      @(posedge clk); #1;
      tx_valid = 1'b0;
      checks++; if (tx !== 1'b0)
         begin errors++; $display("FAIL rst_mid_start: got %b want 0", tx); end
      // Centre of data bit 3: 16*4 + 8 clocks after the start edge.
      repeat (72) @(posedge clk);
      #1;
      checks++; if (fifo_count !== 3'd1)
         begin errors++; $display("FAIL rst_mid_count_before: got %0d want 1", fifo_count); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1)
         begin errors++; $display("FAIL rst_mid_tx_async: got %b want 1", tx); end
      checks++; if (fifo_count !== 3'd0)
         begin errors++; $display("FAIL rst_mid_count_async: got %0d want 0", fifo_count); end
      checks++; if (busy !== 1'b0 || tx_ready !== 1'b1)
         begin errors++; $display("FAIL rst_mid_flags: got busy=%b ready=%b want busy=0 ready=1", busy, tx_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fork
         begin
            @(negedge clk);
            tx_data  = 8'h81;
            tx_valid = 1'b1;
            @(posedge clk); #1;
            tx_valid = 1'b0;
         end
         rx_frame(bits, fall, ok);
      join
      checks++; if (!ok || bits !== frame_of(8'h81))
         begin errors++; $display("FAIL rst_mid_after_frame: got %b want %b", bits, frame_of(8'h81)); end
      watch_idle(2 * FRAME_CYC, falls);
      checks++; if (falls !== 0)
         begin errors++; $display("FAIL rst_mid_stale_frames: got %0d want 0", falls); end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_byte(8'hA5, "single");
      test_back_to_back();
      test_fifo_full();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_single_byte(8'h07, "parity07");
      test_single_byte(8'h03, "parity03");
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
